// File: rtl/mio_pkg.sv
// Shared types and constants for the CPU memory/IO bus controller.
// Device index map, FSM encoding and the wait-counter sizing helper.
package mio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } mio_state_e;

   localparam int MIO_ADDR_W = 32;
   localparam int MIO_DATA_W = 32;

   localparam int DEV_RAM  = 0;
   localparam int DEV_GPIO = 1;
   localparam int DEV_CNT  = 2;
   localparam int DEV_VGA  = 3;

   // Enough bits to hold TIMEOUT-1; a disabled timeout still needs one bit.
   function automatic int cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side and device-side signals of the memory/IO bus controller.
// master: the controller itself; slave: the CPU core plus the attached devices.
interface mio_bus_ctrl_if
   import mio_pkg::*;
#(
   parameter int ADDR_W  = MIO_ADDR_W,
   parameter int DATA_W  = MIO_DATA_W,
   parameter int NUM_DEV = 4
);
   logic                      cpu_req;
   logic                      cpu_we;
   logic [ADDR_W-1:0]         cpu_addr;
   logic [DATA_W-1:0]         cpu_wdata;
   logic [DATA_W-1:0]         cpu_rdata;
   logic                      cpu_ack;
   logic                      cpu_err;
   logic                      cpu_mio;
   logic [NUM_DEV-1:0]        dev_sel;
   logic                      dev_we;
   logic [ADDR_W-1:0]         dev_addr;
   logic [DATA_W-1:0]         dev_wdata;
   logic [NUM_DEV*DATA_W-1:0] dev_rdata;
   logic [NUM_DEV-1:0]        dev_ready;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_ready,
      output cpu_rdata, cpu_ack, cpu_err, cpu_mio,
      output dev_sel, dev_we, dev_addr, dev_wdata
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_ready,
      input  cpu_rdata, cpu_ack, cpu_err, cpu_mio,
      input  dev_sel, dev_we, dev_addr, dev_wdata
   );
endinterface

// File: rtl/mio_addr_dec.sv
// Device decode: range-checks the top address field and builds the one-hot select.
module mio_addr_dec #(
   parameter int NUM_DEV   = 4,
   parameter int DEV_SEL_W = 4
) (
   input  logic [DEV_SEL_W-1:0] idx,
   output logic                 mapped,
   output logic [NUM_DEV-1:0]   onehot
);

   // Range check and one-hot expansion of the device index.
   always_comb begin
      mapped = (int'(idx) < NUM_DEV);
      onehot = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         onehot[i] = mapped && (int'(idx) == i);
      end
   end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Multi-slave memory/IO bus controller: device decode, wait states until the
// selected slave is ready, timeout and unmapped-access error reporting.
module mio_bus_ctrl
   import mio_pkg::*;
#(
   parameter int ADDR_W    = MIO_ADDR_W,
   parameter int DATA_W    = MIO_DATA_W,
   parameter int NUM_DEV   = 4,
   parameter int DEV_SEL_W = 4,
   parameter int TIMEOUT   = 15
) (
   input logic           clk,
   input logic           reset,
   mio_bus_ctrl_if.master bus
);

   localparam int CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   mio_state_e          state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [DATA_W-1:0]   cpu_rdata_r;
   logic                cpu_ack_r;
   logic                cpu_err_r;
   logic                cpu_mio_r;
   logic [NUM_DEV-1:0]  dev_sel_r;
   logic                dev_we_r;
   logic [ADDR_W-1:0]   dev_addr_r;
   logic [DATA_W-1:0]   dev_wdata_r;

   logic                mapped_s;
   logic [NUM_DEV-1:0]  onehot_s;
   logic [DATA_W-1:0]   sel_rdata_s;
   logic                sel_ready_s;

   mio_addr_dec #(
      .NUM_DEV   (NUM_DEV),
      .DEV_SEL_W (DEV_SEL_W)
   ) u_addr_dec (
      .idx    (bus.cpu_addr[ADDR_W-1 -: DEV_SEL_W]),
      .mapped (mapped_s),
      .onehot (onehot_s)
   );

   // Read-data mux keyed on the latched one-hot select, so unselected slaves never leak in.
   always_comb begin
      sel_rdata_s = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         sel_rdata_s = sel_rdata_s | (bus.dev_rdata[i*DATA_W +: DATA_W] & {DATA_W{dev_sel_r[i]}});
      end
   end

   assign sel_ready_s = |(bus.dev_ready & dev_sel_r);

   // Bus FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         cpu_rdata_r <= '0;
         cpu_ack_r   <= 1'b0;
         cpu_err_r   <= 1'b0;
         cpu_mio_r   <= 1'b0;
         dev_sel_r   <= '0;
         dev_we_r    <= 1'b0;
         dev_addr_r  <= '0;
         dev_wdata_r <= '0;
      end else begin
         cpu_ack_r <= 1'b0;
         cpu_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.cpu_req) begin
                  dev_addr_r  <= bus.cpu_addr;
                  dev_wdata_r <= bus.cpu_wdata;
                  cnt_r       <= '0;
                  cpu_mio_r   <= 1'b1;
                  if (mapped_s) begin
                     state_r   <= ACCESS;
                     dev_sel_r <= onehot_s;
                     dev_we_r  <= bus.cpu_we;
                  end else begin
                     state_r <= ERR;
                  end
               end
            end
            ACCESS: begin
               // Ready wins over a timeout landing in the same cycle.
               if (sel_ready_s) begin
                  if (!dev_we_r) begin
                     cpu_rdata_r <= sel_rdata_s;
                  end
                  state_r   <= DONE;
                  dev_sel_r <= '0;
                  dev_we_r  <= 1'b0;
               end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                  state_r   <= ERR;
                  dev_sel_r <= '0;
                  dev_we_r  <= 1'b0;
               end else if (cnt_r != CNT_MAX) begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end
            end
            DONE: begin
               cpu_ack_r <= 1'b1;
               cpu_mio_r <= 1'b0;
               state_r   <= IDLE;
            end
            ERR: begin
               cpu_ack_r   <= 1'b1;
               cpu_err_r   <= 1'b1;
               cpu_rdata_r <= '0;
               cpu_mio_r   <= 1'b0;
               dev_sel_r   <= '0;
               dev_we_r    <= 1'b0;
               state_r     <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               cpu_mio_r <= 1'b0;
               dev_sel_r <= '0;
               dev_we_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_rdata = cpu_rdata_r;
   assign bus.cpu_ack   = cpu_ack_r;
   assign bus.cpu_err   = cpu_err_r;
   assign bus.cpu_mio   = cpu_mio_r;
   assign bus.dev_sel   = dev_sel_r;
   assign bus.dev_we    = dev_we_r;
   assign bus.dev_addr  = dev_addr_r;
   assign bus.dev_wdata = dev_wdata_r;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: transaction-level timeline model checked
// every cycle, plus hand-computed latency/data pins for the directed scenarios.
module tb_mio_bus_ctrl;

   localparam int NUM_DEV = 4;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mio_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_DEV(NUM_DEV)) bus ();

   mio_bus_ctrl #(
      .ADDR_W(32), .DATA_W(32), .NUM_DEV(NUM_DEV), .DEV_SEL_W(4), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] slave_data [NUM_DEV];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Transaction model: one access described by its request edge and timeline.
   bit          chk_en = 1'b0;
   bit          txn_valid = 1'b0;
   int          req_cyc = 0;
   int          n_access = 0;
   bit          exp_err = 1'b0;
   bit          exp_we = 1'b0;
   logic [3:0]  exp_sel = 4'b0000;
   logic [31:0] exp_addr = 32'h0;
   logic [31:0] exp_wdata = 32'h0;
   logic [31:0] model_rdata = 32'h0;

   int last_ack_cyc = -100;
   int ack_cnt = 0, err_cnt = 0, sel_cnt = 0, we_cnt = 0, mio_low = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Observation counters used by the hand-computed pins.
   always @(negedge clk) begin
      if (bus.cpu_ack) begin
         last_ack_cyc = cyc;
         ack_cnt++;
      end
      if (bus.cpu_err) err_cnt++;
      if (bus.dev_sel != 4'b0000) sel_cnt++;
      if (bus.dev_we) we_cnt++;
      if (!bus.cpu_mio) mio_low++;
   end

   // Per-cycle comparison of the DUT against the transaction timeline.
   always @(negedge clk) begin
      if (chk_en) begin
         int slot;
         bit in_acc, in_busy, at_ack;
         slot    = cyc - req_cyc;
         in_acc  = txn_valid && (slot >= 0) && (slot < n_access);
         in_busy = txn_valid && (slot >= 0) && (slot <= n_access);
         at_ack  = txn_valid && (slot == n_access + 1);
         check("dev_sel", bus.dev_sel, in_acc ? exp_sel : 4'b0000);
         check("dev_we", bus.dev_we, in_acc && exp_we);
         check("cpu_mio", bus.cpu_mio, in_busy);
         check("cpu_ack", bus.cpu_ack, at_ack);
         check("cpu_err", bus.cpu_err, at_ack && exp_err);
         if (in_acc) begin
            check("dev_addr", bus.dev_addr, exp_addr);
            check("dev_wdata", bus.dev_wdata, exp_wdata);
         end
         if (at_ack) check("cpu_rdata", bus.cpu_rdata, model_rdata);
      end
   end

   // Issue one access; the selected slave is not ready for its first w ACCESS cycles.
   // Entered and left just after a falling edge; returns in the ack cycle.
   task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int w, input logic [3:0] others, input bit hold);
      int idx;
      idx = int'(addr[31:28]);
      txn_valid = 1'b1;
      req_cyc   = cyc + 1;
      exp_we    = we;
      exp_addr  = addr;
      exp_wdata = wdata;
      if (idx >= NUM_DEV) begin
         n_access = 0;
         exp_err  = 1'b1;
         exp_sel  = 4'b0000;
      end else begin
         exp_sel = 4'b0001 << idx;
         if ((TIMEOUT != 0) && (w >= TIMEOUT)) begin
            n_access = TIMEOUT;
            exp_err  = 1'b1;
         end else begin
            n_access = w + 1;
            exp_err  = 1'b0;
         end
      end
      if (exp_err) model_rdata = 32'h0;
      else if (!we) model_rdata = slave_data[idx];
      last_ack_cyc  = -100;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      bus.dev_ready = others;
      for (int s = 0; s <= n_access + 1; s++) begin
         @(negedge clk); #1;
         if (s == 0 && !hold) bus.cpu_req = 1'b0;
         bus.dev_ready = others;
         if (idx < NUM_DEV) bus.dev_ready[idx] = (s >= w);
      end
   endtask

   task automatic clr_counts();
      ack_cnt = 0; err_cnt = 0; sel_cnt = 0; we_cnt = 0; mio_low = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      slave_data[0] = 32'hA5A5_0001;
      slave_data[1] = 32'h1111_2222;
      slave_data[2] = 32'hDEAD_BEEF;
      slave_data[3] = 32'hCAFE_F00D;
      bus.dev_rdata = {slave_data[3], slave_data[2], slave_data[1], slave_data[0]};
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'h0;
      bus.cpu_wdata = 32'h0;
      bus.dev_ready = 4'b0000;
      reset = 1'b0;

      #2;
      check("rst_rdata", bus.cpu_rdata, 32'h0);
      check("rst_ack", bus.cpu_ack, 1'b0);
      check("rst_err", bus.cpu_err, 1'b0);
      check("rst_mio", bus.cpu_mio, 1'b0);
      check("rst_sel", bus.dev_sel, 4'b0000);
      check("rst_we", bus.dev_we, 1'b0);
      check("rst_addr", bus.dev_addr, 32'h0);
      check("rst_wdata", bus.dev_wdata, 32'h0);

      idle(1);
      reset  = 1'b1;
      chk_en = 1'b1;
      idle(1);

      // Zero-wait read of slave 2.
      clr_counts();
      do_txn(1'b0, 32'h2000_0010, 32'h0, 0, 4'b1111, 1'b0);
      check("t1_latency", last_ack_cyc - req_cyc, 2);
      check("t1_sel_cycles", sel_cnt, 1);
      check("t1_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
      check("t1_err_count", err_cnt, 0);
      idle(2);

      // Write to slave 0 with three wait states; read data must survive.
      clr_counts();
      do_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 3, 4'b1110, 1'b0);
      check("t2_latency", last_ack_cyc - req_cyc, 5);
      check("t2_we_cycles", we_cnt, 4);
      check("t2_rdata_kept", bus.cpu_rdata, 32'hDEAD_BEEF);
      idle(2);

      // Timeout on slave 1 while the other slaves report ready.
      clr_counts();
      do_txn(1'b0, 32'h1000_0000, 32'h0, 1000, 4'b1101, 1'b0);
      check("t3_latency", last_ack_cyc - req_cyc, 16);
      check("t3_sel_cycles", sel_cnt, 15);
      check("t3_err_count", err_cnt, 1);
      check("t3_rdata", bus.cpu_rdata, 32'h0);
      idle(2);

      // Unmapped device index 5.
      clr_counts();
      do_txn(1'b0, 32'h5000_0000, 32'h0, 0, 4'b1111, 1'b0);
      check("t4_latency", last_ack_cyc - req_cyc, 1);
      check("t4_sel_cycles", sel_cnt, 0);
      check("t4_err_count", err_cnt, 1);
      idle(2);

      // Ready arrives exactly when the counter reaches TIMEOUT-1.
      clr_counts();
      do_txn(1'b0, 32'h3000_0020, 32'h0, TIMEOUT - 1, 4'b0000, 1'b0);
      check("t6a_latency", last_ack_cyc - req_cyc, 16);
      check("t6a_err_count", err_cnt, 0);
      check("t6a_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
      idle(2);

      // Back-to-back with cpu_req held high through the first access.
      clr_counts();
      do_txn(1'b0, 32'h2000_0000, 32'h0, 0, 4'b1111, 1'b1);
      check("t6b_latency1", last_ack_cyc - req_cyc, 2);
      do_txn(1'b1, 32'h3000_0008, 32'h0F0F_0F0F, 1, 4'b0000, 1'b0);
      check("t6b_latency2", last_ack_cyc - req_cyc, 3);
      check("t6b_ack_count", ack_cnt, 2);
      check("t6b_mio_low", mio_low, 2);
      idle(2);

      // Reset in the second ACCESS cycle aborts the access.
      chk_en = 1'b0;
      clr_counts();
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'h1000_0040;
      bus.dev_ready = 4'b0000;
      idle(1);
      bus.cpu_req = 1'b0;
      idle(1);
      check("t5_sel_before", bus.dev_sel, 4'b0010);
      reset = 1'b0;
      #1;
      check("t5_rdata", bus.cpu_rdata, 32'h0);
      check("t5_sel", bus.dev_sel, 4'b0000);
      check("t5_mio", bus.cpu_mio, 1'b0);
      check("t5_we", bus.dev_we, 1'b0);
      check("t5_addr", bus.dev_addr, 32'h0);
      idle(1);
      reset = 1'b1;
      idle(3);
      check("t5_no_ack", ack_cnt, 0);
      model_rdata = 32'h0;
      txn_valid   = 1'b0;
      chk_en      = 1'b1;
      idle(1);

      clr_counts();
      do_txn(1'b0, 32'h0000_0000, 32'h0, 2, 4'b0000, 1'b0);
      check("t5_after_latency", last_ack_cyc - req_cyc, 4);
      check("t5_after_rdata", bus.cpu_rdata, 32'hA5A5_0001);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
Parametrised memory/IO bus controller between the multi-cycle CPU core and up to NUM_DEV memory-mapped slaves (RAM, GPIO, counters, VGA).
- Generalises the single-slave, always-ready MIO path: decodes the device from the top address bits, inserts wait states until the selected slave's ready, and enforces a timeout.
- Reports a bus error for unmapped or stalled accesses.
- Sits directly under the CPU top; the CPU memory port attaches to the cpu_* side.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_DEV, 4, number of slaves (1..16)
DEV_SEL_W, 4, device index = cpu_addr[ADDR_W-1 -: DEV_SEL_W]
TIMEOUT, 15, max ACCESS cycles without ready before error; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  access request, sampled only in IDLE
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, registered, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle error pulse, coincident with cpu_ack
cpu_mio  out  1  busy, high whenever state != IDLE
dev_sel  out  NUM_DEV  one-hot slave select
dev_we  out  1  write strobe to the selected slave
dev_addr  out  ADDR_W  latched address
dev_wdata  out  DATA_W  latched write data
dev_rdata  in  NUM_DEV*DATA_W  slave read buses; slave i at [i*DATA_W +: DATA_W]
dev_ready  in  NUM_DEV  per-slave ready

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - Outputs: cpu_rdata=0, cpu_ack=0, cpu_err=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0.
  - Wait counter=0.
  - Reset mid-access aborts the access without an ack.
- FSM states IDLE, ACCESS, DONE, ERR. All outputs are registered.
- IDLE:
  - On cpu_req=1, latch addr, wdata, we and idx=cpu_addr[ADDR_W-1 -: DEV_SEL_W].
  - If idx>=NUM_DEV, go to ERR.
  - Otherwise go to ACCESS, with dev_sel[idx]=1 and dev_we=latched we; clear the counter.
  - The CPU may drop cpu_req after one cycle. A req held high past DONE starts a new access on the next IDLE cycle.
- ACCESS:
  - dev_sel, dev_we, dev_addr and dev_wdata stay stable.
  - If dev_ready[idx]=1: on a read capture dev_rdata slice idx into cpu_rdata; on a write leave cpu_rdata unchanged. Then go to DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1, go to ERR.
  - Else increment the counter.
  - dev_ready of unselected slaves is ignored.
  - The ready test has priority over timeout in the same cycle.
- DONE: cpu_ack=1 for one cycle; dev_sel=0, dev_we=0; return to IDLE.
- ERR: cpu_ack=1 and cpu_err=1 for one cycle; cpu_rdata=0; dev_sel=0, dev_we=0; return to IDLE.
- Latency with ready tied high (zero-wait slave):
  - req sampled at edge 0; ACCESS during cycle 1; ack visible after edge 2.
  - Each ready-low cycle adds one cycle.
- Counter width is clog2(TIMEOUT+1), minimum 1. No wrap is possible when TIMEOUT!=0. With TIMEOUT=0 the counter saturates and never errors.
- dev_we is never high outside ACCESS. At most one dev_sel bit is high at any time.

Decomposition:
- Shared package mio_pkg holds:
  - state enum {IDLE, ACCESS, DONE, ERR}, 2-bit encoding
  - default ADDR_W/DATA_W constants
  - the device index map constants: RAM=0, GPIO=1, CNT=2, VGA=3
- One natural sub-module, mio_addr_dec: combinational idx extract, range check, one-hot generation.

Test Plan:
1. Read, zero-wait: NUM_DEV=4, dev_ready=4'b1111, slave2 rdata=32'hDEAD_BEEF; read addr 32'h2000_0010 -> dev_sel=4'b0100 for one cycle, cpu_ack two cycles after req, cpu_rdata=32'hDEAD_BEEF, cpu_err=0.
2. Write with waits: write 32'h1234_5678 to 32'h0000_0004; dev_ready[0] low for 3 ACCESS cycles -> dev_we and dev_wdata stable 4 cycles, ack 5 cycles after req.
3. Timeout: TIMEOUT=15, read slave1 with ready stuck low -> exactly 15 ACCESS cycles, then cpu_ack=cpu_err=1, cpu_rdata=0, dev_sel=0.
4. Unmapped device: addr 32'h5000_0000 with NUM_DEV=4 -> no dev_sel, ack+err one cycle after req.
5. Reset abort: assert reset=0 in the 2nd ACCESS cycle -> all outputs 0 immediately (asynchronous), no ack. After release, a req completes normally.
6. Edge cases:
   - Ready arriving on the cycle the counter hits TIMEOUT-1 -> DONE, not ERR.
   - Back-to-back req held high -> two acks separated by the IDLE cycle, cpu_mio low for exactly one cycle.
